// File: rtl/color_blender_stream.sv
// color_blender_stream: 3-stage pipelined OpenGL-style framebuffer blender with valid/ready flow control.
// Optional bitwise logic-op equations (5..7) are built only when COLOR_BLENDER_LOGIC_OP_EN is defined.
module color_blender_stream #(
    parameter int SUB_PIXEL_WIDTH = 8,
    parameter int USER_WIDTH      = 16
) (
    input  logic                         aclk,
    input  logic                         reset,
    input  logic                         confEnable,
    input  logic [3:0]                   confSFactor,
    input  logic [3:0]                   confDFactor,
    input  logic [2:0]                   confEquation,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] confConstColor,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] s_srcColor,
    input  logic [4*SUB_PIXEL_WIDTH-1:0] s_dstColor,
    input  logic [USER_WIDTH-1:0]        s_user,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [4*SUB_PIXEL_WIDTH-1:0] m_color,
    output logic [USER_WIDTH-1:0]        m_user
);
    localparam int W  = SUB_PIXEL_WIDTH;
    localparam int PW = 4 * W;
    localparam logic [W-1:0]   ONE  = '1;
    localparam logic [2*W:0]   HALF = {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};

    // Channel k lives at bits [k*W +: W]; channel 0 is alpha because pixels are packed {R,G,B,A}.
    function automatic logic [W-1:0] factor(input logic [3:0] sel, input logic is_alpha,
                                            input logic [W-1:0] cs, input logic [W-1:0] cd,
                                            input logic [W-1:0] cc, input logic [W-1:0] as,
                                            input logic [W-1:0] ad, input logic [W-1:0] ac);
        logic [W-1:0] f;
        case (sel)
            4'd1:    f = ONE;
            4'd2:    f = cd;
            4'd3:    f = cs;
            4'd4:    f = ONE - cd;
            4'd5:    f = ONE - cs;
            4'd6:    f = as;
            4'd7:    f = ONE - as;
            4'd8:    f = ad;
            4'd9:    f = ONE - ad;
            4'd10:   f = is_alpha ? ONE : ((as < (ONE - ad)) ? as : (ONE - ad));
            4'd11:   f = cc;
            4'd12:   f = ONE - cc;
            4'd13:   f = ac;
            4'd14:   f = ONE - ac;
            default: f = '0;
        endcase
        return f;
    endfunction

    // Rounded f*c/(2^W-1) without a divider.
    function automatic logic [W-1:0] scale(input logic [W-1:0] f, input logic [W-1:0] c);
        logic [2*W:0] q;
        logic [2*W:0] r;
        q = ({{(W+1){1'b0}}, f} * {{(W+1){1'b0}}, c}) + HALF;
        r = (q + (q >> W)) >> W;
        return W'(r);
    endfunction

    function automatic logic [W-1:0] equate(input logic [2:0] eq, input logic [W-1:0] s,
                                            input logic [W-1:0] d, input logic [W-1:0] cs,
                                            input logic [W-1:0] cd);
        logic [W:0]   sum;
        logic [W-1:0] r;
        sum = {1'b0, s} + {1'b0, d};
        case (eq)
            3'd1:    r = (s > d) ? (s - d) : '0;
            3'd2:    r = (d > s) ? (d - s) : '0;
            3'd3:    r = (cs < cd) ? cs : cd;
            3'd4:    r = (cs > cd) ? cs : cd;
            default: r = sum[W] ? ONE : sum[W-1:0];
        endcase
        return r;
    endfunction

    logic                  advance;
    logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic                  en1_q, en1_d, en2_q, en2_d;
    logic [2:0]            eq1_q, eq1_d, eq2_q, eq2_d;
    logic [PW-1:0]         fs1_q, fs1_d, fd1_q, fd1_d, src1_q, src1_d, dst1_q, dst1_d;
    logic [PW-1:0]         st2_q, st2_d, dt2_q, dt2_d, src2_q, src2_d, dst2_q, dst2_d;
    logic [PW-1:0]         color3_q, color3_d;
    logic [USER_WIDTH-1:0] user1_q, user1_d, user2_q, user2_d, user3_q, user3_d;
    logic [PW-1:0]         blend;

    // Handshake: a beat moves on a cycle where valid && ready. The whole pipe is one stall
    // domain: advance = m_ready || !m_valid, s_ready = advance; bubbles ride along uncompressed.
    always_comb begin
        advance  = m_ready || !v3_q;
        v1_d     = v1_q;     v2_d    = v2_q;    v3_d    = v3_q;
        en1_d    = en1_q;    en2_d   = en2_q;
        eq1_d    = eq1_q;    eq2_d   = eq2_q;
        fs1_d    = fs1_q;    fd1_d   = fd1_q;
        src1_d   = src1_q;   dst1_d  = dst1_q;
        st2_d    = st2_q;    dt2_d   = dt2_q;
        src2_d   = src2_q;   dst2_d  = dst2_q;
        user1_d  = user1_q;  user2_d = user2_q; user3_d = user3_q;
        color3_d = color3_q;
        blend    = '0;

        for (int k = 0; k < 4; k++) begin
            blend[k*W +: W] = equate(eq2_q, st2_q[k*W +: W], dt2_q[k*W +: W],
                                     src2_q[k*W +: W], dst2_q[k*W +: W]);
        end
`ifdef COLOR_BLENDER_LOGIC_OP_EN
        case (eq2_q)
            3'd5:    blend = src2_q ^ dst2_q;
            3'd6:    blend = src2_q & dst2_q;
            3'd7:    blend = src2_q | dst2_q;
            default: ;
        endcase
`endif
        if (!en2_q) blend = src2_q;

        if (advance) begin
            v1_d    = s_valid;
            en1_d   = confEnable;
            eq1_d   = confEquation;
            src1_d  = s_srcColor;
            dst1_d  = s_dstColor;
            user1_d = s_user;
            for (int k = 0; k < 4; k++) begin
                fs1_d[k*W +: W] = factor(confSFactor, k == 0, s_srcColor[k*W +: W],
                                         s_dstColor[k*W +: W], confConstColor[k*W +: W],
                                         s_srcColor[W-1:0], s_dstColor[W-1:0], confConstColor[W-1:0]);
                fd1_d[k*W +: W] = factor(confDFactor, k == 0, s_srcColor[k*W +: W],
                                         s_dstColor[k*W +: W], confConstColor[k*W +: W],
                                         s_srcColor[W-1:0], s_dstColor[W-1:0], confConstColor[W-1:0]);
            end

            v2_d    = v1_q;
            en2_d   = en1_q;
            eq2_d   = eq1_q;
            src2_d  = src1_q;
            dst2_d  = dst1_q;
            user2_d = user1_q;
            for (int k = 0; k < 4; k++) begin
                st2_d[k*W +: W] = scale(fs1_q[k*W +: W], src1_q[k*W +: W]);
                dt2_d[k*W +: W] = scale(fd1_q[k*W +: W], dst1_q[k*W +: W]);
            end

            v3_d     = v2_q;
            user3_d  = user2_q;
            color3_d = blend;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            v1_q     <= 1'b0;  v2_q    <= 1'b0;  v3_q    <= 1'b0;
            en1_q    <= 1'b0;  en2_q   <= 1'b0;
            eq1_q    <= '0;    eq2_q   <= '0;
            fs1_q    <= '0;    fd1_q   <= '0;
            src1_q   <= '0;    dst1_q  <= '0;
            st2_q    <= '0;    dt2_q   <= '0;
            src2_q   <= '0;    dst2_q  <= '0;
            user1_q  <= '0;    user2_q <= '0;    user3_q <= '0;
            color3_q <= '0;
        end else begin
            v1_q     <= v1_d;   v2_q    <= v2_d;   v3_q    <= v3_d;
            en1_q    <= en1_d;  en2_q   <= en2_d;
            eq1_q    <= eq1_d;  eq2_q   <= eq2_d;
            fs1_q    <= fs1_d;  fd1_q   <= fd1_d;
            src1_q   <= src1_d; dst1_q  <= dst1_d;
            st2_q    <= st2_d;  dt2_q   <= dt2_d;
            src2_q   <= src2_d; dst2_q  <= dst2_d;
            user1_q  <= user1_d; user2_q <= user2_d; user3_q <= user3_d;
            color3_q <= color3_d;
        end
    end

    assign s_ready = advance;
    assign m_valid = v3_q;
    assign m_color = color3_q;
    assign m_user  = user3_q;

endmodule

// File: tb/tb_color_blender_stream.sv
// Self-checking bench for color_blender_stream: directed test-plan vectors plus randomized
// traffic against a per-channel arithmetic reference model and an expected-value queue.
`timescale 1ns/1ps
module tb_color_blender_stream;
    localparam int W    = 8;
    localparam int UW   = 16;
    localparam int MAXV = 255;

    logic          aclk = 1'b0;
    logic          reset = 1'b1;
    logic          confEnable = 1'b1;
    logic [3:0]    confSFactor = 4'd1;
    logic [3:0]    confDFactor = 4'd0;
    logic [2:0]    confEquation = 3'd0;
    logic [31:0]   confConstColor = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_srcColor = '0;
    logic [31:0]   s_dstColor = '0;
    logic [UW-1:0] s_user = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [31:0]   m_color;
    logic [UW-1:0] m_user;

    logic [4*W-1:0] exp_q[$];
    logic [UW-1:0]  exp_user_q[$];
    int total = 0;
    int bad = 0;
    int accepted = 0;

    color_blender_stream #(.SUB_PIXEL_WIDTH(W), .USER_WIDTH(UW)) dut (
        .aclk(aclk), .reset(reset),
        .confEnable(confEnable), .confSFactor(confSFactor), .confDFactor(confDFactor),
        .confEquation(confEquation), .confConstColor(confConstColor),
        .s_valid(s_valid), .s_ready(s_ready), .s_srcColor(s_srcColor),
        .s_dstColor(s_dstColor), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_color(m_color), .m_user(m_user)
    );

    // Clock; inputs change only at posedge+1, outputs are sampled at negedge.
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int rnd_div(input int f, input int c);
        return (2 * f * c + MAXV) / (2 * MAXV);
    endfunction

    function automatic int fac(input int sel, input bit is_a, input int cs, input int cd,
                               input int k, input int as, input int ad, input int ak);
        int r;
        case (sel)
            1:       r = MAXV;
            2:       r = cd;
            3:       r = cs;
            4:       r = MAXV - cd;
            5:       r = MAXV - cs;
            6:       r = as;
            7:       r = MAXV - as;
            8:       r = ad;
            9:       r = MAXV - ad;
            10:      r = is_a ? MAXV : ((as < MAXV - ad) ? as : MAXV - ad);
            11:      r = k;
            12:      r = MAXV - k;
            13:      r = ak;
            14:      r = MAXV - ak;
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] model_pixel(input bit en, input int sf, input int df,
                                                input int eq, input logic [31:0] cc,
                                                input logic [31:0] src, input logic [31:0] dst);
        int cs[4];
        int cd[4];
        int kc[4];
        int fs, fd, sv, dv, v;
        logic [31:0] res;
        if (!en) return src;
`ifdef COLOR_BLENDER_LOGIC_OP_EN
        if (eq == 5) return src ^ dst;
        if (eq == 6) return src & dst;
        if (eq == 7) return src | dst;
`endif
        // index 0 = R ... 3 = A
        for (int i = 0; i < 4; i++) begin
            cs[i] = int'(src[31-8*i -: 8]);
            cd[i] = int'(dst[31-8*i -: 8]);
            kc[i] = int'(cc[31-8*i -: 8]);
        end
        res = '0;
        for (int i = 0; i < 4; i++) begin
            fs = fac(sf, i == 3, cs[i], cd[i], kc[i], cs[3], cd[3], kc[3]);
            fd = fac(df, i == 3, cs[i], cd[i], kc[i], cs[3], cd[3], kc[3]);
            sv = rnd_div(fs, cs[i]);
            dv = rnd_div(fd, cd[i]);
            case (eq)
                1:       v = sv - dv;
                2:       v = dv - sv;
                3:       v = (cs[i] < cd[i]) ? cs[i] : cd[i];
                4:       v = (cs[i] > cd[i]) ? cs[i] : cd[i];
                default: v = sv + dv;
            endcase
            if (v > MAXV) v = MAXV;
            if (v < 0) v = 0;
            res[31-8*i -: 8] = 8'(v);
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_beat(input bit en, input logic [3:0] sf, input logic [3:0] df,
                             input logic [2:0] eq, input logic [31:0] cc,
                             input logic [31:0] src, input logic [31:0] dst,
                             input logic [UW-1:0] user);
        int n = 0;
        confEnable = en; confSFactor = sf; confDFactor = df; confEquation = eq;
        confConstColor = cc; s_srcColor = src; s_dstColor = dst; s_user = user;
        s_valid = 1'b1;
        @(negedge aclk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge aclk);
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
            @(posedge aclk); #1;
            s_valid = 1'b0;
        end else begin
            @(posedge aclk); #1;
            s_valid = 1'b0;
            accepted++;
            exp_q.push_back(model_pixel(en, int'(sf), int'(df), int'(eq), cc, src, dst));
            exp_user_q.push_back(user);
        end
    endtask

    task automatic recv_beat(output logic [31:0] c, output logic [UW-1:0] u,
                             output logic [31:0] ec, output logic [UW-1:0] eu);
        int n = 0;
        @(negedge aclk);
        while (!(m_valid && m_ready) && n < 200) begin
            n++;
            @(negedge aclk);
        end
        c = m_color; u = m_user;
        ec = 'x; eu = 'x;
        if (!(m_valid && m_ready)) begin
            total++; bad++;
            $display("FAIL recv_timeout: m_valid=%0b m_ready=%0b after %0d cycles, required a beat",
                     m_valid, m_ready, n);
        end else if (exp_q.size() > 0) begin
            ec = exp_q.pop_front();
            eu = exp_user_q.pop_front();
        end
        @(posedge aclk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; m_ready = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %0b want 0", m_valid); end
        total++; if (m_color !== 32'h0) begin bad++; $display("FAIL reset_m_color: got %h want 00000000", m_color); end
        total++; if (m_user !== 16'h0) begin bad++; $display("FAIL reset_m_user: got %h want 0000", m_user); end
        @(posedge aclk); #1;
        reset = 1'b0;
        @(negedge aclk);
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready: got %0b want 1", s_ready); end
        @(posedge aclk); #1;
    endtask

    task automatic test_latency();
        int lat;
        logic [31:0] got;
        m_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            confEnable = (pass == 0);
            confSFactor = (pass == 0) ? 4'd1 : 4'd0;
            confDFactor = 4'd0; confEquation = 3'd0; confConstColor = 32'h0;
            s_srcColor = 32'h80402010; s_dstColor = 32'hFFFFFFFF; s_user = 16'h0;
            s_valid = 1'b1;
            @(negedge aclk);
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL latency_accept%0d: s_ready=%0b want 1", pass, s_ready); end
            @(posedge aclk); #1;
            s_valid = 1'b0;
            lat = 0; got = '0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                @(negedge aclk);
                if (m_valid) begin lat = c; got = m_color; end
            end
            total++; if (lat != 3) begin bad++; $display("FAIL latency_cycles%0d: got %0d want 3", pass, lat); end
            total++; if (got !== 32'h80402010) begin bad++; $display("FAIL latency_color%0d: got %h want 80402010", pass, got); end
            @(posedge aclk); #1;
        end
    endtask

    task automatic test_blend_vectors();
        logic [3:0]  vsf[4];
        logic [3:0]  vdf[4];
        logic [2:0]  veq[4];
        logic [31:0] vsrc[4];
        logic [31:0] vdst[4];
        logic [31:0] vexp[4];
        logic [31:0] c, ec;
        logic [UW-1:0] u, eu;
        vsf = '{4'd6, 4'd1, 4'd1, 4'd1};
        vdf = '{4'd7, 4'd1, 4'd1, 4'd1};
        veq = '{3'd0, 3'd0, 3'd2, 3'd4};
        vsrc = '{32'hFF000080, 32'hC0C0C0C0, 32'h10101010, 32'h10101010};
        vdst = '{32'h0000FFFF, 32'h80808080, 32'h08080808, 32'h08080808};
        vexp = '{32'h80007FBF, 32'hFFFFFFFF, 32'h00000000, 32'h10101010};
        m_ready = 1'b1;
        fork
            for (int i = 0; i < 4; i++)
                send_beat(1'b1, vsf[i], vdf[i], veq[i], 32'h0, vsrc[i], vdst[i], UW'(16'h100 + i));
            for (int i = 0; i < 4; i++) begin
                recv_beat(c, u, ec, eu);
                total++; if (c !== vexp[i]) begin bad++; $display("FAIL vector%0d_color: got %h want %h", i, c, vexp[i]); end
                total++; if (u !== UW'(16'h100 + i)) begin bad++; $display("FAIL vector%0d_user: got %h want %h", i, u, 16'h100 + i); end
            end
        join
    endtask

    task automatic test_backpressure();
        bit have;
        bit unstable;
        logic [31:0] c0, c, ec;
        logic [UW-1:0] u0, u, eu;
        m_ready = 1'b0; accepted = 0; have = 1'b0; unstable = 1'b0; c0 = '0; u0 = '0;
        fork
            for (int k = 1; k <= 5; k++)
                send_beat(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 4)), $urandom, $urandom, $urandom, UW'(k));
            begin
                for (int n = 0; n < 10; n++) begin
                    @(negedge aclk);
                    if (m_valid) begin
                        if (!have) begin have = 1'b1; c0 = m_color; u0 = m_user; end
                        else if (m_color !== c0 || m_user !== u0) unstable = 1'b1;
                    end
                end
                total++; if (accepted != 3) begin bad++; $display("FAIL bp_accepted: got %0d want 3", accepted); end
                total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready: got %0b want 0", s_ready); end
                total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL bp_m_valid: got %0b want 1", m_valid); end
                total++; if (m_user !== UW'(1)) begin bad++; $display("FAIL bp_head_user: got %0d want 1", m_user); end
                total++; if (unstable !== 1'b0) begin bad++; $display("FAIL bp_stable: outputs changed while stalled, got %h want %h", m_color, c0); end
                @(posedge aclk); #1;
                m_ready = 1'b1;
                for (int k = 1; k <= 5; k++) begin
                    recv_beat(c, u, ec, eu);
                    total++; if (u !== UW'(k)) begin bad++; $display("FAIL bp_order%0d: got user %0d want %0d", k, u, k); end
                    total++; if (c !== ec) begin bad++; $display("FAIL bp_color%0d: got %h want %h", k, c, ec); end
                end
            end
        join
    endtask

    task automatic test_config_capture();
        logic [31:0] c, ec;
        logic [UW-1:0] u, eu;
        m_ready = 1'b1;
        fork
            begin
                send_beat(1'b1, 4'd1, 4'd1, 3'd0, 32'h0, 32'h60606060, 32'h20202020, UW'(16'hA));
                send_beat(1'b1, 4'd1, 4'd1, 3'd1, 32'h0, 32'h60606060, 32'h20202020, UW'(16'hB));
            end
            begin
                recv_beat(c, u, ec, eu);
                total++; if (c !== 32'h80808080) begin bad++; $display("FAIL cfg_a_color: got %h want 80808080", c); end
                total++; if (u !== UW'(16'hA)) begin bad++; $display("FAIL cfg_a_user: got %h want 000a", u); end
                recv_beat(c, u, ec, eu);
                total++; if (c !== 32'h40404040) begin bad++; $display("FAIL cfg_b_color: got %h want 40404040", c); end
                total++; if (u !== UW'(16'hB)) begin bad++; $display("FAIL cfg_b_user: got %h want 000b", u); end
            end
        join
    endtask

    task automatic test_random(input int nbeats);
        fork
            for (int i = 0; i < nbeats; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge aclk); #1; end
                send_beat($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, UW'($urandom));
            end
            begin
                int got = 0;
                int idle = 0;
                logic [31:0] ec;
                logic [UW-1:0] eu;
                while (got < nbeats && idle < 2000) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    @(negedge aclk);
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL rand_extra: unexpected beat color %h user %h", m_color, m_user);
                        end else begin
                            ec = exp_q.pop_front();
                            eu = exp_user_q.pop_front();
                            total++; if (m_color !== ec) begin bad++; $display("FAIL rand_color%0d: got %h want %h", got, m_color, ec); end
                            total++; if (m_user !== eu) begin bad++; $display("FAIL rand_user%0d: got %h want %h", got, m_user, eu); end
                        end
                        got++; idle = 0;
                    end else begin
                        idle++;
                    end
                    @(posedge aclk); #1;
                end
                if (got < nbeats) begin
                    total++; bad++;
                    $display("FAIL rand_timeout: got %0d beats want %0d", got, nbeats);
                end
            end
        join
        m_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        logic [31:0] c, ec;
        logic [UW-1:0] u, eu;
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++)
            send_beat(1'b1, 4'd1, 4'd0, 3'd0, 32'h0, 32'h11223344 + k, 32'h0, UW'(16'h50 + k));
        #2 reset = 1'b1;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midreset_m_valid: got %0b want 0", m_valid); end
        total++; if (m_color !== 32'h0) begin bad++; $display("FAIL midreset_m_color: got %h want 00000000", m_color); end
        exp_q.delete();
        exp_user_q.delete();
        repeat (2) @(posedge aclk);
        #1 reset = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge aclk);
            if (m_valid) stale++;
        end
        total++; if (stale != 0) begin bad++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale); end
        @(posedge aclk); #1;
        fork
            send_beat(1'b1, 4'd6, 4'd7, 3'd0, 32'h0, 32'hFF000080, 32'h0000FFFF, UW'(16'h77));
            begin
                recv_beat(c, u, ec, eu);
                total++; if (c !== 32'h80007FBF) begin bad++; $display("FAIL midreset_recover_color: got %h want 80007fbf", c); end
                total++; if (u !== UW'(16'h77)) begin bad++; $display("FAIL midreset_recover_user: got %h want 0077", u); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_latency();
        test_blend_vectors();
        test_backpressure();
        test_config_capture();
        test_random(400);
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
